store_write_buffer: RTL and testbench

//  Write-side companion to the data memory read port. Accepts CPU store requests (SB/SH/SW),

---
 rtl/store_write_buffer.sv | 186 ++++++++++++++++++
 tb/tb_store_write_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// -----------------------------------------------------------------------------
// store_write_buffer
//
// This block handles the write side of data memory. It takes CPU store requests
// (byte, half and word), turns each one into a word address, byte enables and
// data placed in the correct byte lanes, and holds them in a DEPTH-entry FIFO.
// It sends one entry per cycle to the RAM write port in any cycle where the RAM
// is not busy with a load. It also reports a hazard when a load address matches
// the word of a store that is still pending.
//
// Handshake: a store transfers on a rising edge where st_valid && st_ready.
// st_ready depends only on registered state and on reset. A request that is
// misaligned or uses the reserved size still completes the handshake. It is
// dropped instead of queued, and st_err pulses high for the next cycle.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   st_valid   in   store request valid
//   st_ready   out  buffer can accept a store this cycle
//   st_addr    in   store byte address
//   st_data    in   store data, right-justified
//   st_size    in   00 byte, 01 half, 10 word, 11 reserved
//   st_err     out  one-cycle pulse after a rejected store
//   mem_we     out  RAM write strobe (registered)
//   mem_addr   out  word-aligned RAM write address (registered)
//   mem_wdata  out  lane-positioned write data (registered)
//   mem_be     out  byte enables (registered)
//   mem_busy   in   RAM port used by a load this cycle, so no drain
//   ld_addr    in   address of the load in progress
//   ld_hazard  out  a queued or in-flight store targets the same word
//   count      out  number of entries held in the FIFO
//   empty      out  FIFO empty and no write in flight
// -----------------------------------------------------------------------------
module store_write_buffer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          st_valid,
    output logic                          st_ready,
    input  logic [ADDRESS_WIDTH-1:0]      st_addr,
    input  logic [DATA_WIDTH-1:0]         st_data,
    input  logic [1:0]                    st_size,
    output logic                          st_err,
    output logic                          mem_we,
    output logic [ADDRESS_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [DATA_WIDTH/8-1:0]       mem_be,
    input  logic                          mem_busy,
    input  logic [ADDRESS_WIDTH-1:0]      ld_addr,
    output logic                          ld_hazard,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          empty
);

    localparam int BEW = DATA_WIDTH / 8;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int WAW = ADDRESS_WIDTH - 2;

    // FIFO storage. An entry is valid only when it lies in the window of
    // count slots starting at rd_ptr, so the storage itself needs no reset.
    logic [WAW-1:0]        q_word  [DEPTH];
    logic [DATA_WIDTH-1:0] q_wdata [DEPTH];
    logic [BEW-1:0]        q_be    [DEPTH];

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt_q;
    logic                  err_q;
    logic                  we_q;
    logic [WAW-1:0]        mem_word_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BEW-1:0]        be_q;

    logic [BEW-1:0]        al_be;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic                  al_bad;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // The low two bits of the load address do not take part in the
    // word-granular hazard compare.
    logic unused_ld_bits;
    assign unused_ld_bits = ^ld_addr[1:0];

    // Place the right-justified store data into byte lanes and build the enables.
    always_comb begin
        al_be    = '0;
        al_wdata = '0;
        al_bad   = 1'b0;
        case (st_size)
            2'b00: begin
                al_be    = BEW'(1) << st_addr[1:0];
                al_wdata = {BEW{st_data[7:0]}};
            end
            2'b01: begin
                if (st_addr[0]) begin
                    al_bad = 1'b1;
                end else begin
                    al_be    = BEW'(3) << st_addr[1:0];
                    al_wdata = {(DATA_WIDTH/16){st_data[15:0]}};
                end
            end
            2'b10: begin
                if (st_addr[1:0] != 2'b00) begin
                    al_bad = 1'b1;
                end else begin
                    al_be    = '1;
                    al_wdata = st_data;
                end
            end
            default: al_bad = 1'b1;
        endcase
    end

    // A store cannot bypass a full FIFO, even in a cycle where the FIFO pops.
    assign st_ready = (cnt_q < CW'(DEPTH)) && reset;
    assign accept   = st_valid && st_ready;
    assign push     = accept && !al_bad;
    assign pop      = (cnt_q != '0) && !mem_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            mem_word_q <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            err_q <= accept && al_bad;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            // When no drain happens, the address, data and enables hold their
            // last values and only the strobe drops.
            we_q <= pop;
            if (pop) begin
                mem_word_q <= q_word[rd_ptr];
                wdata_q    <= q_wdata[rd_ptr];
                be_q       <= q_be[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_word[wr_ptr]  <= st_addr[ADDRESS_WIDTH-1:2];
            q_wdata[wr_ptr] <= al_wdata;
            q_be[wr_ptr]    <= al_be;
        end
    end

    // Hazard check. Slot i is valid when its distance from rd_ptr, taken
    // modulo DEPTH, is less than count.
    logic [PW-1:0] slot_off;
    always_comb begin
        slot_off  = '0;
        ld_hazard = we_q && (mem_word_q == ld_addr[ADDRESS_WIDTH-1:2]);
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PW'(i) - rd_ptr;
            if ((CW'(slot_off) < cnt_q) && (q_word[i] == ld_addr[ADDRESS_WIDTH-1:2]))
                ld_hazard = 1'b1;
        end
    end

    assign st_err    = err_q;
    assign mem_we    = we_q;
    assign mem_addr  = {mem_word_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign count     = cnt_q;
    assign empty     = (cnt_q == '0) && !we_q;

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_busy;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic [2:0]  count;
  logic        empty;

  store_write_buffer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size), .st_err(st_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_busy(mem_busy), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .count(count), .empty(empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: {addr, be, wdata}
  logic [67:0] exp_q[$];

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1;
    st_size  = size;
    st_addr  = addr;
    st_data  = data;
  endtask

  task automatic idle_store();
    st_valid = 1'b0;
    st_size  = 2'b00;
    st_addr  = '0;
    st_data  = '0;
  endtask

  task automatic check_write(input string name);
    logic [67:0] e;
    check({name, "_we"}, {67'd0, mem_we}, 68'd1);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 68'd1, 68'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_data"}, {mem_addr, mem_be, mem_wdata}, e);
    end
  endtask

  initial begin
    vecs[0] = '{2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{2'b00, 32'h0000_0103, 32'h0000_005A, 4'h8, 32'h5A5A_5A5A, 1'b0};
    vecs[2] = '{2'b01, 32'h0000_0102, 32'h0000_1234, 4'hC, 32'h1234_1234, 1'b0};
    vecs[3] = '{2'b01, 32'h0000_0101, 32'h0000_1234, 4'h0, 32'h0000_0000, 1'b1};
    vecs[4] = '{2'b00, 32'h0000_0201, 32'hFFFF_FF77, 4'h2, 32'h7777_7777, 1'b0};
    vecs[5] = '{2'b01, 32'h0000_0300, 32'hAAAA_BEEF, 4'h3, 32'hBEEF_BEEF, 1'b0};
    vecs[6] = '{2'b10, 32'h0000_0106, 32'h1111_2222, 4'h0, 32'h0000_0000, 1'b1};
    vecs[7] = '{2'b11, 32'h0000_0000, 32'h3333_4444, 4'h0, 32'h0000_0000, 1'b1};
    vecs[8] = '{2'b00, 32'h0000_0000, 32'h0000_0001, 4'h1, 32'h0101_0101, 1'b0};

    // reset behaviour, with st_valid held high during reset
    reset    = 1'b0;
    mem_busy = 1'b0;
    ld_addr  = '0;
    drive_store(2'b10, 32'h0000_0100, 32'hDEAD_BEEF);
    cyc();
    cyc();
    check("rst_ready", {67'd0, st_ready}, 68'd0);
    check("rst_we",    {67'd0, mem_we},   68'd0);
    check("rst_count", {65'd0, count},    68'd0);
    check("rst_empty", {67'd0, empty},    68'd1);
    check("rst_err",   {67'd0, st_err},   68'd0);
    idle_store();
    reset = 1'b1;
    #1;
    check("rel_ready", {67'd0, st_ready}, 68'd1);
    cyc();

    // table-driven single stores into an empty buffer
    for (int i = 0; i < 9; i++) begin
      drive_store(vecs[i].size, vecs[i].addr, vecs[i].data);
      cyc();                                    // accept edge
      idle_store();
      check($sformatf("v%0d_err", i),   {67'd0, st_err}, {67'd0, vecs[i].err});
      check($sformatf("v%0d_count", i), {65'd0, count},  vecs[i].err ? 68'd0 : 68'd1);
      check($sformatf("v%0d_we0", i),   {67'd0, mem_we}, 68'd0);
      cyc();                                    // drain edge
      check($sformatf("v%0d_err_gone", i), {67'd0, st_err}, 68'd0);
      check($sformatf("v%0d_we", i), {67'd0, mem_we}, {67'd0, !vecs[i].err});
      if (!vecs[i].err)
        check($sformatf("v%0d_mem", i), {mem_addr, mem_be, mem_wdata},
              {vecs[i].addr & 32'hFFFF_FFFC, vecs[i].be, vecs[i].wdata});
      check($sformatf("v%0d_cnt0", i), {65'd0, count}, 68'd0);
      cyc();
      check($sformatf("v%0d_idle", i),  {67'd0, mem_we}, 68'd0);
      check($sformatf("v%0d_empty", i), {67'd0, empty},  68'd1);
    end

    // fill with mem_busy high: four accepted, fifth refused
    mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_store(2'b10, 32'h0000_0400 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
      #1;
      check($sformatf("fill%0d_ready", i), {67'd0, st_ready}, (i < 4) ? 68'd1 : 68'd0);
      if (i < 4) exp_q.push_back({32'h0000_0400 + 32'(i * 4), 4'hF, 32'hC0DE_0000 + 32'(i)});
      cyc();
    end
    idle_store();
    check("full_count", {65'd0, count},  68'd4);
    check("full_we",    {67'd0, mem_we}, 68'd0);
    mem_busy = 1'b0;
    #1;
    check("full_no_bypass", {67'd0, st_ready}, 68'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_write($sformatf("burst%0d", i));
      check($sformatf("burst%0d_count", i), {65'd0, count}, 68'(3 - i));
    end
    cyc();
    check("burst_done_we",    {67'd0, mem_we}, 68'd0);
    check("burst_done_empty", {67'd0, empty},  68'd1);

    // push and pop in the same cycle
    drive_store(2'b00, 32'h0000_0502, 32'h0000_00AB);
    exp_q.push_back({32'h0000_0500, 4'h4, 32'hABAB_ABAB});
    cyc();
    check("pp_count1", {65'd0, count}, 68'd1);
    drive_store(2'b01, 32'h0000_0600, 32'h0000_CDEF);
    exp_q.push_back({32'h0000_0600, 4'h3, 32'hCDEF_CDEF});
    cyc();
    idle_store();
    check("pp_count_hold", {65'd0, count}, 68'd1);
    check_write("pp_first");
    cyc();
    check_write("pp_second");
    check("pp_count0", {65'd0, count}, 68'd0);
    cyc();
    check("pp_idle", {67'd0, mem_we}, 68'd0);

    // load/store hazard
    mem_busy = 1'b1;
    drive_store(2'b10, 32'h0000_0200, 32'h5555_AAAA);
    cyc();
    idle_store();
    ld_addr = 32'h0000_0202;
    #1;
    check("haz_same_word", {67'd0, ld_hazard}, 68'd1);
    ld_addr = 32'h0000_0204;
    #1;
    check("haz_next_word", {67'd0, ld_hazard}, 68'd0);
    ld_addr  = 32'h0000_0200;
    mem_busy = 1'b0;
    cyc();
    check("haz_inflight_we", {67'd0, mem_we},    68'd1);
    check("haz_inflight",    {67'd0, ld_hazard}, 68'd1);
    cyc();
    check("haz_cleared", {67'd0, ld_hazard}, 68'd0);

    // reset while draining with three entries left
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_store(2'b10, 32'h0000_0700 + 32'(i * 4), 32'h7000_0000 + 32'(i));
      cyc();
    end
    idle_store();
    mem_busy = 1'b0;
    cyc();
    check("mid_we",    {67'd0, mem_we}, 68'd1);
    check("mid_count", {65'd0, count},  68'd3);
    reset = 1'b0;
    #1;
    check("mid_rst_we",    {67'd0, mem_we},   68'd0);
    check("mid_rst_count", {65'd0, count},    68'd0);
    check("mid_rst_mem",   {mem_addr, mem_be, mem_wdata}, 68'd0);
    check("mid_rst_ready", {67'd0, st_ready}, 68'd0);
    check("mid_rst_empty", {67'd0, empty},    68'd1);
    cyc();
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check($sformatf("post_rst%0d_we", i), {67'd0, mem_we}, 68'd0);
    end
    check("post_rst_count", {65'd0, count}, 68'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
